gemm_output_writer: RTL and testbench
=====================================

# gemm_output_writer

Writeback stage directly downstream of the GeMM controller and MAC array. Captures one M×N result tile whenever the controller flags a valid result, optionally saturates each accumulator to the output width, and writes the tile row by row into the output SRAM through a req/gnt port with computed row-major addresses. Holds one tile: it accepts a new tile only when idle and flags any tile it has to drop.

## Interface
- AddrWidth, 16, address and size width
- M, 4, tile rows (spatial M parallelism)
- N, 4, tile columns (spatial N parallelism)
- AccWidth, 32, signed accumulator width per element
- OutWidth, 8, signed output element width
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- clear_i  in  1  synchronous clear: abort writeback, zero counters and flags
- result_valid_i  in  1  tile present on result_i this cycle
- result_i  in  M*N*AccWidth  element (r,c) at bits [(r*N+c)*AccWidth +: AccWidth]
- m_idx_i  in  AddrWidth  M-tile index of the presented tile
- n_idx_i  in  AddrWidth  N-tile index of the presented tile
- N_size_i  in  AddrWidth  full N dimension; multiple of N
- base_addr_i  in  AddrWidth  output matrix base word address
- ready_o  out  1  tile can be accepted this cycle
- mem_req_o  out  1  write request
- mem_gnt_i  in  1  write grant
- mem_addr_o  out  AddrWidth  word address
- mem_wdata_o  out  N*OutWidth  column c at [c*OutWidth +: OutWidth]
- tile_count_o  out  AddrWidth  tiles fully written since reset/clear
- overflow_o  out  1  sticky: a tile was dropped

## Operation
- States: Idle, Write.
- Idle: ready_o=1. On result_valid_i, register result_i, m_idx_i, n_idx_i, and row counter=0, then move to Write.
- Write: ready_o=0. mem_req_o=1, data = converted row r of the captured tile, mem_addr_o = base_addr_i + (m_idx*M + r)*(N_size_i/N) + n_idx, computed at full precision and truncated to AddrWidth (wraps modulo 2^AddrWidth).
- Grant on row r<M-1: r increments. Grant on r=M-1: tile_count_o increments (wraps at 2^AddrWidth), state returns to Idle.
- mem_req_o, address, and data remain stable until granted; req is never withdrawn except by clear_i or reset.
- result_valid_i in Write: the tile is dropped, the captured tile is unaffected, and overflow_o sets and stays set until clear_i or reset.
- clear_i takes priority over every event in the same cycle: Idle, r=0, tile_count_o=0, overflow_o=0, and any result_valid_i in that cycle is ignored.
- Element conversion is signed; see Configuration.

## Timing
- Reset values: ready_o=1, mem_req_o=0, mem_addr_o=0, mem_wdata_o=0, tile_count_o=0, overflow_o=0; state Idle.
- mem_req_o and all address and data outputs are registered or derived only from registered state. They carry no combinational path from mem_gnt_i or result_valid_i.
- Tile accepted at cycle t: first request at t+1. With mem_gnt_i held high, rows go out on t+1..t+M and ready_o=1 at t+M+1.
- Minimum tile-to-tile spacing is M+1 cycles. A result_valid_i at t+M is dropped.
- Asserting rst_ni low mid-tile aborts the tile immediately. No partial-row bookkeeping is kept.

## Configuration
- GEMM_OUTPUT_SATURATE_EN defined: each element clamps to [-2^(OutWidth-1), 2^(OutWidth-1)-1].
- Undefined: each element is truncated to its low OutWidth bits (two's-complement wrap).
- With OutWidth == AccWidth, both options pass the value through unchanged.

## Structure
- Shared package gemm_output_pkg: the state enum, and a function that converts AccWidth to OutWidth (saturate or truncate under the macro).
- Row counter: reuse ceiling_counter (Width=AddrWidth, ceiling M-1, tick = mem_req_o && mem_gnt_i, clear on accept or clear_i). Its last_value_o drives the Write→Idle transition.

## Test plan
- Single tile: M=N=4, base=0x100, N_size=8, m_idx=1, n_idx=1, gnt tied 1 → addresses 0x109, 0x10B, 0x10D, 0x10F on 4 consecutive cycles; tile_count_o=1; ready_o back at t+5.
- Backpressure: gnt low for 3 cycles on row 2 → mem_req_o, address, and data stay constant throughout; no row is skipped or repeated.
- Saturation: element 300 and element -200, OutWidth=8. With GEMM_OUTPUT_SATURATE_EN → 0x7F, 0x80. Without → 0x2C, 0x38.
- Overflow: second result_valid_i while in Write → first tile written intact; overflow_o=1 and stays set; tile_count_o=1.
- Clear mid-tile: clear_i at row 2 → mem_req_o=0 next cycle, ready_o=1, tile_count_o=0, overflow_o=0.
- Async reset at row 1 → all outputs at reset values before the next clock edge; a new tile then writes normally from row 0.

Source files
------------

// File: rtl/gemm_output_pkg.sv
// Shared definitions for the GeMM output writeback stage.
//   state_t / StIdle / StWrite : writer FSM encoding
//   conv_elem()                : accumulator -> output element conversion
// Build option: GEMM_OUTPUT_SATURATE_EN selects clamping; when it is undefined
// elements are truncated to their low bits (two's-complement wrap).
package gemm_output_pkg;

  typedef logic [0:0] state_t;

  localparam state_t StIdle  = 1'b0;
  localparam state_t StWrite = 1'b1;

  // Widest accumulator the conversion helper handles; callers sign-extend into it
  // and take the low out_width bits of the result.
  localparam int unsigned ConvWidth = 64;

  function automatic logic [ConvWidth-1:0] conv_elem(input logic signed [ConvWidth-1:0] acc,
                                                     input int unsigned out_width);
`ifdef GEMM_OUTPUT_SATURATE_EN
    logic signed [ConvWidth-1:0] hi;
    logic signed [ConvWidth-1:0] lo;
    hi = (64'sd1 <<< (out_width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_width - 1));
    if (acc > hi) begin
      return hi;
    end else if (acc < lo) begin
      return lo;
    end
    return acc;
`else
    logic [ConvWidth-1:0] mask;
    if (out_width >= ConvWidth) begin
      mask = '1;
    end else begin
      mask = (64'd1 << out_width) - 64'd1;
    end
    return acc & mask;
`endif
  endfunction

endpackage

// File: rtl/ceiling_counter.sv
// Wrapping up-counter: counts 0..ceiling_i on tick_i, then wraps to 0.
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   clear_i        : synchronous clear to 0 (wins over tick_i)
//   tick_i         : advance by one
//   ceiling_i      : last value before wrapping
//   count_o        : current count
//   last_value_o   : count_o == ceiling_i
module ceiling_counter #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             tick_i,
  input  logic [Width-1:0] ceiling_i,
  output logic [Width-1:0] count_o,
  output logic             last_value_o
);

  logic [Width-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (tick_i) begin
      if (count_q == ceiling_i) begin
        count_d = '0;
      end else begin
        count_d = count_q + Width'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o      = count_q;
  assign last_value_o = (count_q == ceiling_i);

endmodule

// File: rtl/gemm_output_writer.sv
// GeMM output writeback: captures one MxN accumulator tile, converts each element to
// OutWidth, and writes it row by row through a req/gnt SRAM port at row-major
// addresses base + (m_idx*M + r)*(N_size/N) + n_idx (modulo 2^AddrWidth).
//   clk_i, rst_ni           : clock, asynchronous active-low reset
//   clear_i                 : synchronous abort; zeroes tile count and overflow flag
//   result_valid_i/result_i : incoming tile, element (r,c) at (r*N+c)*AccWidth
//   m_idx_i, n_idx_i        : tile indices, captured with the tile
//   N_size_i, base_addr_i   : output matrix geometry, used live during writeback
//   ready_o                 : idle, a tile would be accepted this cycle
//   mem_req_o/mem_gnt_i     : write handshake; mem_addr_o, mem_wdata_o held until grant
//   tile_count_o            : tiles fully written since reset/clear
//   overflow_o              : sticky, a tile arrived while busy and was dropped
// Build option: GEMM_OUTPUT_SATURATE_EN clamps elements instead of truncating.
module gemm_output_writer
  import gemm_output_pkg::*;
#(
  parameter int unsigned AddrWidth = 16,
  parameter int unsigned M         = 4,
  parameter int unsigned N         = 4,
  parameter int unsigned AccWidth  = 32,
  parameter int unsigned OutWidth  = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      clear_i,
  input  logic                      result_valid_i,
  input  logic [M*N*AccWidth-1:0]   result_i,
  input  logic [AddrWidth-1:0]      m_idx_i,
  input  logic [AddrWidth-1:0]      n_idx_i,
  input  logic [AddrWidth-1:0]      N_size_i,
  input  logic [AddrWidth-1:0]      base_addr_i,
  output logic                      ready_o,
  output logic                      mem_req_o,
  input  logic                      mem_gnt_i,
  output logic [AddrWidth-1:0]      mem_addr_o,
  output logic [N*OutWidth-1:0]     mem_wdata_o,
  output logic [AddrWidth-1:0]      tile_count_o,
  output logic                      overflow_o
);

  state_t                    state_d, state_q;
  logic [M*N*AccWidth-1:0]   tile_d, tile_q;
  logic [AddrWidth-1:0]      m_idx_d, m_idx_q;
  logic [AddrWidth-1:0]      n_idx_d, n_idx_q;
  logic [AddrWidth-1:0]      tile_count_d, tile_count_q;
  logic                      overflow_d, overflow_q;

  logic                      accept;
  logic [AddrWidth-1:0]      row_cnt;
  logic                      row_last;
  logic [N*AccWidth-1:0]     row_data;
  logic [N*OutWidth-1:0]     row_conv;
  logic [AddrWidth-1:0]      row_addr;

  assign ready_o   = (state_q == StIdle);
  assign mem_req_o = (state_q == StWrite);
  assign accept    = ready_o && result_valid_i && !clear_i;

  // Row counter restarts on every accepted tile so a clear mid-tile leaves no residue.
  ceiling_counter #(
    .Width (AddrWidth)
  ) u_row_cnt (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .clear_i      (clear_i || accept),
    .tick_i       (mem_req_o && mem_gnt_i),
    .ceiling_i    (AddrWidth'(M - 1)),
    .count_o      (row_cnt),
    .last_value_o (row_last)
  );

  always_comb begin
    state_d      = state_q;
    tile_d       = tile_q;
    m_idx_d      = m_idx_q;
    n_idx_d      = n_idx_q;
    tile_count_d = tile_count_q;
    overflow_d   = overflow_q;
    if (clear_i) begin
      state_d      = StIdle;
      tile_count_d = '0;
      overflow_d   = 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (result_valid_i) begin
            tile_d  = result_i;
            m_idx_d = m_idx_i;
            n_idx_d = n_idx_i;
            state_d = StWrite;
          end
        end
        StWrite: begin
          if (result_valid_i) begin
            overflow_d = 1'b1;
          end
          if (mem_gnt_i && row_last) begin
            state_d      = StIdle;
            tile_count_d = tile_count_q + AddrWidth'(1);
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      tile_q       <= '0;
      m_idx_q      <= '0;
      n_idx_q      <= '0;
      tile_count_q <= '0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      tile_q       <= tile_d;
      m_idx_q      <= m_idx_d;
      n_idx_q      <= n_idx_d;
      tile_count_q <= tile_count_d;
      overflow_q   <= overflow_d;
    end
  end

  // Select the current row of the captured tile.
  always_comb begin
    row_data = '0;
    for (int r = 0; r < M; r++) begin
      if (row_cnt == AddrWidth'(r)) begin
        row_data = tile_q[r*N*AccWidth +: N*AccWidth];
      end
    end
  end

  always_comb begin
    row_conv = '0;
    for (int c = 0; c < N; c++) begin
      row_conv[c*OutWidth +: OutWidth] =
          OutWidth'(conv_elem(64'($signed(row_data[c*AccWidth +: AccWidth])), OutWidth));
    end
  end

  // AddrWidth-wide arithmetic is exact modulo 2^AddrWidth, matching the wrapped address.
  assign row_addr = base_addr_i
                  + (m_idx_q * AddrWidth'(M) + row_cnt) * (N_size_i / AddrWidth'(N))
                  + n_idx_q;

  // Outputs idle at zero so nothing but registered state reaches the port.
  assign mem_addr_o   = mem_req_o ? row_addr : '0;
  assign mem_wdata_o  = mem_req_o ? row_conv : '0;
  assign tile_count_o = tile_count_q;
  assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_gemm_output_writer.sv
// Scoreboard bench for gemm_output_writer: a tile-level model predicts each written row
// and the handshake-visible status; a negedge monitor compares everything the DUT presents.
module tb_gemm_output_writer;

  localparam int AW  = 16;
  localparam int M   = 4;
  localparam int N   = 4;
  localparam int ACW = 32;
  localparam int OW  = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              clear = 1'b0;
  logic              valid = 1'b0;
  logic [M*N*ACW-1:0] res = '0;
  logic [AW-1:0]     m_idx = '0;
  logic [AW-1:0]     n_idx = '0;
  logic [AW-1:0]     nsize = 16'd8;
  logic [AW-1:0]     base = '0;
  logic              gnt = 1'b0;
  logic              ready_o;
  logic              mem_req_o;
  logic [AW-1:0]     mem_addr_o;
  logic [N*OW-1:0]   mem_wdata_o;
  logic [AW-1:0]     tile_count_o;
  logic              overflow_o;

  gemm_output_writer #(
    .AddrWidth (AW),
    .M         (M),
    .N         (N),
    .AccWidth  (ACW),
    .OutWidth  (OW)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .clear_i        (clear),
    .result_valid_i (valid),
    .result_i       (res),
    .m_idx_i        (m_idx),
    .n_idx_i        (n_idx),
    .N_size_i       (nsize),
    .base_addr_i    (base),
    .ready_o        (ready_o),
    .mem_req_o      (mem_req_o),
    .mem_gnt_i      (gnt),
    .mem_addr_o     (mem_addr_o),
    .mem_wdata_o    (mem_wdata_o),
    .tile_count_o   (tile_count_o),
    .overflow_o     (overflow_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0]   addr;
    logic [N*OW-1:0] data;
  } row_t;

  row_t        exp_q[$];
  int          n_checks = 0;
  int          n_fails = 0;
  bit          busy = 1'b0;
  int          rows_left = 0;
  logic [AW-1:0] m_tc = '0;
  bit          m_ovf = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [OW-1:0] conv_ref(input int v);
    int          hi;
    int          lo;
    logic [31:0] u;
    hi = 2 ** (OW - 1) - 1;
    lo = -(2 ** (OW - 1));
`ifdef GEMM_OUTPUT_SATURATE_EN
    if (v > hi) v = hi;
    else if (v < lo) v = lo;
`else
    if (hi < lo) v = 0;
`endif
    u = v;
    return u[OW-1:0];
  endfunction

  // Tile-level model: advances on the same edge the DUT samples its inputs.
  initial begin
    bit            was_busy;
    logic [63:0]   a;
    row_t          row;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n || clear) begin
        busy = 1'b0; rows_left = 0; m_tc = '0; m_ovf = 1'b0;
        exp_q.delete();
      end else begin
        was_busy = busy;
        if (was_busy && valid) m_ovf = 1'b1;
        if (was_busy && gnt) begin
          rows_left--;
          if (rows_left == 0) begin
            busy = 1'b0;
            m_tc = m_tc + 1'b1;
          end
        end
        if (!was_busy && valid) begin
          for (int r = 0; r < M; r++) begin
            a = 64'(base) + (64'(m_idx) * M + r) * (64'(nsize) / N) + 64'(n_idx);
            row.addr = a[AW-1:0];
            for (int c = 0; c < N; c++) begin
              row.data[c*OW +: OW] = conv_ref(int'($signed(res[(r*N+c)*ACW +: ACW])));
            end
            exp_q.push_back(row);
          end
          busy = 1'b1;
          rows_left = M;
        end
      end
    end
  end

  // Monitor: outputs are stable at the falling edge; req&&gnt here means the row is
  // consumed at the next rising edge.
  initial begin
    forever begin
      @(negedge clk);
      check("ready", 64'(ready_o), 64'(!busy));
      check("mem_req", 64'(mem_req_o), 64'(busy));
      check("tile_count", 64'(tile_count_o), 64'(m_tc));
      check("overflow", 64'(overflow_o), 64'(m_ovf));
      if (mem_req_o) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fails++;
          $display("FAIL row_unexpected: got request addr 0x%0h, expected no request",
                   mem_addr_o);
        end else begin
          check("row_addr", 64'(mem_addr_o), 64'(exp_q[0].addr));
          check("row_data", 64'(mem_wdata_o), 64'(exp_q[0].data));
          if (gnt) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int rand_elem();
    case ($urandom % 3)
      0:       return int'($urandom);
      1:       return int'($urandom_range(0, 600)) - 300;
      default: return int'($urandom_range(0, 255)) - 128;
    endcase
  endfunction

  task automatic new_tile();
    for (int i = 0; i < M * N; i++) res[i*ACW +: ACW] = rand_elem();
  endtask

  logic [AW-1:0] single_addr [M];

  initial begin
    single_addr = '{16'h109, 16'h10B, 16'h10D, 16'h10F};

    // Reset values
    #12;
    check("rst_ready", 64'(ready_o), 64'd1);
    check("rst_req", 64'(mem_req_o), 64'd0);
    check("rst_addr", 64'(mem_addr_o), 64'd0);
    check("rst_wdata", 64'(mem_wdata_o), 64'd0);
    check("rst_tile_count", 64'(tile_count_o), 64'd0);
    check("rst_overflow", 64'(overflow_o), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Single tile, grant tied high
    base = 16'h100; nsize = 16'd8; m_idx = 16'd1; n_idx = 16'd1; gnt = 1'b1;
    new_tile();
    valid = 1'b1;
    tick();
    valid = 1'b0;
    for (int r = 0; r < M; r++) begin
      check("single_addr", 64'(mem_addr_o), 64'(single_addr[r]));
      tick();
    end
    check("single_ready_back", 64'(ready_o), 64'd1);
    check("single_count", 64'(tile_count_o), 64'd1);

    // Conversion of out-of-range elements
    new_tile();
    res[0*ACW +: ACW] = 32'sd300;
    res[1*ACW +: ACW] = -32'sd200;
    valid = 1'b1;
    tick();
    valid = 1'b0;
`ifdef GEMM_OUTPUT_SATURATE_EN
    check("conv_pos", 64'(mem_wdata_o[7:0]), 64'h7F);
    check("conv_neg", 64'(mem_wdata_o[15:8]), 64'h80);
`else
    check("conv_pos", 64'(mem_wdata_o[7:0]), 64'h2C);
    check("conv_neg", 64'(mem_wdata_o[15:8]), 64'h38);
`endif
    repeat (M) tick();

    // Backpressure on row 2
    base = 16'h200; nsize = 16'd16; m_idx = 16'd2; n_idx = 16'd3;
    new_tile();
    valid = 1'b1;
    tick();
    valid = 1'b0;
    tick();
    tick();
    gnt = 1'b0;
    repeat (3) begin
      check("bp_addr", 64'(mem_addr_o), 64'h22B);
      check("bp_req", 64'(mem_req_o), 64'd1);
      tick();
    end
    gnt = 1'b1;
    repeat (M) tick();

    // Overflow: second tile while writing
    new_tile();
    valid = 1'b1;
    tick();
    new_tile();
    tick();
    valid = 1'b0;
    repeat (M) tick();
    check("ovf_flag", 64'(overflow_o), 64'd1);
    check("ovf_count", 64'(tile_count_o), 64'd4);
    tick();
    check("ovf_sticky", 64'(overflow_o), 64'd1);

    // Clear at row 2
    new_tile();
    valid = 1'b1;
    tick();
    valid = 1'b0;
    tick();
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_req", 64'(mem_req_o), 64'd0);
    check("clr_ready", 64'(ready_o), 64'd1);
    check("clr_count", 64'(tile_count_o), 64'd0);
    check("clr_ovf", 64'(overflow_o), 64'd0);

    // Asynchronous reset at row 1
    new_tile();
    valid = 1'b1;
    tick();
    valid = 1'b0;
    tick();
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_ready", 64'(ready_o), 64'd1);
    check("arst_req", 64'(mem_req_o), 64'd0);
    check("arst_addr", 64'(mem_addr_o), 64'd0);
    check("arst_wdata", 64'(mem_wdata_o), 64'd0);
    check("arst_count", 64'(tile_count_o), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    base = 16'h040; nsize = 16'd8; m_idx = 16'd0; n_idx = 16'd0;
    new_tile();
    valid = 1'b1;
    tick();
    valid = 1'b0;
    check("arst_restart_addr", 64'(mem_addr_o), 64'h040);
    repeat (M) tick();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      if (!busy && ($urandom % 4 == 0)) begin
        base  = AW'($urandom);
        nsize = AW'($urandom_range(1, 64) * N);
      end
      valid = ($urandom % 3 == 0);
      if (valid) begin
        new_tile();
        m_idx = AW'($urandom);
        n_idx = AW'($urandom_range(0, 15));
      end
      gnt   = ($urandom % 4 != 0);
      clear = ($urandom % 60 == 0);
      tick();
    end

    // Drain with a bounded wait
    valid = 1'b0; clear = 1'b0; gnt = 1'b1;
    for (int i = 0; i < 20 && busy; i++) tick();
    check("drain_idle", 64'(busy), 64'd0);
    tick();
    check("drain_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
